saxil_to_dev: RTL and testbench

- AXI-Lite slave that converts AXI-Lite transactions into a device-side memory request port (req/gnt/rvalid, same style as the Ibex data interface).
- Lets an external AXI-Lite master (host, DMA, debug) reach the Ibex-side scratchpad or register targets.
- Exactly one transaction is outstanding on the device side at a time.
- When a read and a write are both ready, they are arbitrated round-robin.

---
 rtl/saxil_pkg.sv | 20 ++
 rtl/saxil_to_dev_if.sv | 39 +++
 rtl/saxil_to_dev_hold_reg.sv | 31 +++
 rtl/saxil_to_dev.sv | 153 +++++++++++++++
 tb/tb_saxil_to_dev.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/saxil_pkg.sv
// Shared types and constants for the AXI-Lite to device-port bridge.
package saxil_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_B,
        S_R
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Map a captured device error onto the AXI response code.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/saxil_to_dev_if.sv
// AXI-Lite bus bundle; slave modport faces the bridge, master faces the host.
interface saxil_to_dev_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/saxil_to_dev_hold_reg.sv
// One-deep valid/ready holding register. Ready comes only from the
// registered full flag, so there is no combinational path from valid.
module axil_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // Capture on handshake, release when the consumer takes the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            data <= in_data;
        end
    end

    assign in_ready = !full;

endmodule

// File: rtl/saxil_to_dev.sv
// AXI-Lite slave bridging to a req/gnt/rvalid device port, one device
// transaction in flight, round-robin between pending read and write.
module saxil_to_dev
    import saxil_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    saxil_to_dev_if.slave       s_axi,
    output logic                dev_req_o,
    output logic [31:0]         dev_addr_o,
    output logic                dev_we_o,
    output logic [3:0]          dev_be_o,
    output logic [31:0]         dev_wdata_o,
    input  logic                dev_gnt_i,
    input  logic                dev_rvalid_i,
    input  logic                dev_err_i,
    input  logic [31:0]         dev_rdata_i
);

    if (AXI_DATA_WIDTH != 32) begin : g_bad_dw
        $error("saxil_to_dev: AXI_DATA_WIDTH must be 32");
    end
    if (AXI_ADDR_WIDTH < 3 || AXI_ADDR_WIDTH > 32) begin : g_bad_aw
        $error("saxil_to_dev: AXI_ADDR_WIDTH must be in 3..32");
    end

    logic                      aw_full, w_full, ar_full;
    logic [AXI_ADDR_WIDTH-1:0] aw_data, ar_data;
    logic [35:0]               w_data;
    logic                      clr_w, clr_r;

    axil_hold_reg #(.WIDTH(AXI_ADDR_WIDTH)) u_aw (
        .clk, .rst,
        .in_valid (s_axi.awvalid), .in_ready (s_axi.awready), .in_data (s_axi.awaddr),
        .clr (clr_w), .full (aw_full), .data (aw_data)
    );

    axil_hold_reg #(.WIDTH(36)) u_w (
        .clk, .rst,
        .in_valid (s_axi.wvalid), .in_ready (s_axi.wready), .in_data ({s_axi.wstrb, s_axi.wdata}),
        .clr (clr_w), .full (w_full), .data (w_data)
    );

    axil_hold_reg #(.WIDTH(AXI_ADDR_WIDTH)) u_ar (
        .clk, .rst,
        .in_valid (s_axi.arvalid), .in_ready (s_axi.arready), .in_data (s_axi.araddr),
        .clr (clr_r), .full (ar_full), .data (ar_data)
    );

    state_e      state_q, state_d;
    logic        rr_last_wr_q, is_wr_q, err_q;
    logic [31:0] rdata_q, addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        wr_pend, rd_pend, issue_wr, issue_rd;
    logic [31:0] aw_addr32, ar_addr32;

    assign wr_pend = aw_full && w_full;
    assign rd_pend = ar_full;

    // Word-align and zero-extend the held addresses onto the 32-bit device bus.
    always_comb begin
        aw_addr32 = '0;
        ar_addr32 = '0;
        aw_addr32[AXI_ADDR_WIDTH-1:2] = aw_data[AXI_ADDR_WIDTH-1:2];
        ar_addr32[AXI_ADDR_WIDTH-1:2] = ar_data[AXI_ADDR_WIDTH-1:2];
    end

    // Next-state, arbitration and holding-register release.
    always_comb begin
        state_d  = state_q;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        clr_w    = 1'b0;
        clr_r    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_pend && (!rd_pend || !rr_last_wr_q)) issue_wr = 1'b1;
                else if (rd_pend)                            issue_rd = 1'b1;
                if (issue_wr || issue_rd) state_d = S_REQ;
            end
            S_REQ: begin
                if (dev_gnt_i) begin
                    clr_w   = is_wr_q;
                    clr_r   = !is_wr_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dev_rvalid_i) state_d = is_wr_q ? S_B : S_R;
            end
            S_B: begin
                if (s_axi.bready) state_d = S_IDLE;
            end
            S_R: begin
                if (s_axi.rready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Device request fields, arbitration history and captured response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_wr_q <= 1'b0;
            is_wr_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (issue_wr) begin
                rr_last_wr_q <= 1'b1;
                is_wr_q      <= 1'b1;
                addr_q       <= aw_addr32;
                be_q         <= w_data[35:32];
                wdata_q      <= w_data[31:0];
            end else if (issue_rd) begin
                rr_last_wr_q <= 1'b0;
                is_wr_q      <= 1'b0;
                addr_q       <= ar_addr32;
                be_q         <= 4'hF;
                wdata_q      <= '0;
            end
            if (state_q == S_WAIT && dev_rvalid_i) begin
                err_q   <= dev_err_i;
                rdata_q <= dev_rdata_i;
            end
        end
    end

    assign dev_req_o   = (state_q == S_REQ);
    assign dev_addr_o  = addr_q;
    assign dev_we_o    = is_wr_q;
    assign dev_be_o    = be_q;
    assign dev_wdata_o = wdata_q;

    assign s_axi.bvalid = (state_q == S_B);
    assign s_axi.bresp  = s_axi.bvalid ? resp_of(err_q) : RESP_OKAY;
    assign s_axi.rvalid = (state_q == S_R);
    assign s_axi.rresp  = s_axi.rvalid ? resp_of(err_q) : RESP_OKAY;
    assign s_axi.rdata  = (s_axi.rvalid && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_saxil_to_dev.sv
// Directed bench for saxil_to_dev with a configurable zero/stall device model.
module tb_saxil_to_dev;
    import saxil_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    saxil_to_dev_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    logic        dev_req_o, dev_we_o;
    logic [31:0] dev_addr_o, dev_wdata_o;
    logic [3:0]  dev_be_o;
    logic        dev_gnt_i, dev_rvalid_i, dev_err_i;
    logic [31:0] dev_rdata_i;

    saxil_to_dev #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi        (axi),
        .dev_req_o    (dev_req_o),
        .dev_addr_o   (dev_addr_o),
        .dev_we_o     (dev_we_o),
        .dev_be_o     (dev_be_o),
        .dev_wdata_o  (dev_wdata_o),
        .dev_gnt_i    (dev_gnt_i),
        .dev_rvalid_i (dev_rvalid_i),
        .dev_err_i    (dev_err_i),
        .dev_rdata_i  (dev_rdata_i)
    );

    int checks   = 0;
    int failures = 0;

    // device model configuration
    int          gnt_dly = 0;
    int          rv_dly  = 1;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = '0;

    // Device: grant after gnt_dly cycles of req, respond rv_dly cycles after grant.
    initial begin : dev_model
        dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_err_i = 1'b0; dev_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_err_i = 1'b0; dev_rdata_i = '0;
            if (dev_req_o) begin
                for (int i = 0; i < gnt_dly; i++) begin @(posedge clk); #1; end
                dev_gnt_i = 1'b1;
                @(posedge clk); #1;
                dev_gnt_i = 1'b0;
                for (int i = 1; i < rv_dly; i++) begin @(posedge clk); #1; end
                dev_rvalid_i = 1'b1; dev_err_i = cfg_err; dev_rdata_i = cfg_rdata;
            end
        end
    end

    typedef struct {
        logic        req, we, bv, rv, awr, wr, arr;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic [1:0]  bresp, rresp;
    } snap_t;
    snap_t s [0:31];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Advance n cycles from cycle 0, sampling outputs mid-cycle into s[1..n].
    // AW may be delayed to cycle aw_at; BREADY rises at cycle b_at when b_at>0.
    task automatic run(input int n, input int aw_at, input int b_at);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 1) begin axi.wvalid = 1'b0; axi.arvalid = 1'b0; end
            if (k == aw_at + 1) axi.awvalid = 1'b0;
            if (k == aw_at && k > 0) axi.awvalid = 1'b1;
            if (k == b_at && k > 0) axi.bready = 1'b1;
            @(negedge clk);
            s[k].req = dev_req_o;   s[k].we = dev_we_o;     s[k].addr = dev_addr_o;
            s[k].be = dev_be_o;     s[k].wdata = dev_wdata_o;
            s[k].bv = axi.bvalid;   s[k].bresp = axi.bresp;
            s[k].rv = axi.rvalid;   s[k].rresp = axi.rresp; s[k].rdata = axi.rdata;
            s[k].awr = axi.awready; s[k].wr = axi.wready;   s[k].arr = axi.arready;
        end
    endtask

    task automatic test_reset();
        axi.awvalid = 0; axi.awaddr = '0; axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0;
        axi.bready = 0; axi.arvalid = 0; axi.araddr = '0; axi.rready = 0;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (dev_req_o !== 1'b0 || axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) begin
            failures++; $display("FAIL rst_hold_valid got req=%b bv=%b rv=%b exp 0", dev_req_o, axi.bvalid, axi.rvalid);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
            failures++; $display("FAIL rst_ready got %b exp 111", {axi.awready, axi.wready, axi.arready});
        end
        checks++;
        if ({dev_req_o, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp} !== 7'b0 || axi.rdata !== 32'h0) begin
            failures++; $display("FAIL rst_outputs got req=%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h exp 0",
                                 dev_req_o, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata);
        end
        checks++;
        if (dev_addr_o !== 32'h0 || dev_wdata_o !== 32'h0 || dev_be_o !== 4'h0 || dev_we_o !== 1'b0) begin
            failures++; $display("FAIL rst_dev_bus got addr=%h wdata=%h be=%h we=%b exp 0", dev_addr_o, dev_wdata_o, dev_be_o, dev_we_o);
        end
    endtask

    task automatic test_single_write();
        tick();
        gnt_dly = 0; rv_dly = 1; cfg_err = 0;
        axi.bready = 1; axi.rready = 1;
        axi.awaddr = 32'h1006; axi.awvalid = 1;
        axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'b0011; axi.wvalid = 1;
        run(6, 0, 0);
        checks++;
        if (s[1].awr !== 1'b0 || s[1].wr !== 1'b0 || s[1].req !== 1'b0) begin
            failures++; $display("FAIL sw_c1 got awr=%b wr=%b req=%b exp 0 0 0", s[1].awr, s[1].wr, s[1].req);
        end
        checks++;
        if (s[2].req !== 1'b1 || s[2].addr !== 32'h1004 || s[2].be !== 4'h3 || s[2].we !== 1'b1 || s[2].wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL sw_req got req=%b addr=%h be=%h we=%b wdata=%h exp 1 00001004 3 1 deadbeef",
                                 s[2].req, s[2].addr, s[2].be, s[2].we, s[2].wdata);
        end
        checks++;
        if (s[3].req !== 1'b0 || s[3].bv !== 1'b0) begin
            failures++; $display("FAIL sw_c3 got req=%b bv=%b exp 0 0", s[3].req, s[3].bv);
        end
        checks++;
        if (s[4].bv !== 1'b1 || s[4].bresp !== 2'b00) begin
            failures++; $display("FAIL sw_b got bv=%b bresp=%b exp 1 00", s[4].bv, s[4].bresp);
        end
        checks++;
        if (s[5].bv !== 1'b0 || s[5].awr !== 1'b1) begin
            failures++; $display("FAIL sw_done got bv=%b awr=%b exp 0 1", s[5].bv, s[5].awr);
        end
    endtask

    task automatic test_w_before_aw();
        int bcnt, reqpre;
        tick();
        axi.awaddr = 32'h40;
        axi.wdata = 32'hCAFE0001; axi.wstrb = 4'hF; axi.wvalid = 1;
        run(10, 3, 0);
        checks++;
        if (s[1].wr !== 1'b0 || s[1].awr !== 1'b1) begin
            failures++; $display("FAIL wfirst_ready got wr=%b awr=%b exp 0 1", s[1].wr, s[1].awr);
        end
        reqpre = 0; bcnt = 0;
        for (int k = 1; k <= 4; k++) if (s[k].req) reqpre++;
        for (int k = 1; k <= 10; k++) if (s[k].bv) bcnt++;
        checks++;
        if (reqpre != 0) begin
            failures++; $display("FAIL wfirst_early_req got %0d req cycles before AW issue exp 0", reqpre);
        end
        checks++;
        if (s[5].req !== 1'b1 || s[5].addr !== 32'h40 || s[5].we !== 1'b1 || s[5].wdata !== 32'hCAFE0001) begin
            failures++; $display("FAIL wfirst_req got req=%b addr=%h we=%b wdata=%h exp 1 00000040 1 cafe0001",
                                 s[5].req, s[5].addr, s[5].we, s[5].wdata);
        end
        checks++;
        if (s[7].bv !== 1'b1 || bcnt != 1) begin
            failures++; $display("FAIL wfirst_b got bv@7=%b bcount=%0d exp 1 1", s[7].bv, bcnt);
        end
    endtask

    task automatic test_read_stall();
        int rq, rc;
        tick();
        gnt_dly = 3; rv_dly = 2; cfg_rdata = 32'h12345678;
        axi.araddr = 32'h20; axi.arvalid = 1;
        run(12, 0, 0);
        rq = 0; rc = 0;
        for (int k = 1; k <= 12; k++) begin
            if (s[k].req) rq++;
            if (s[k].rv) rc++;
        end
        checks++;
        if (rq != 4) begin
            failures++; $display("FAIL rd_req_hold got %0d cycles exp 4", rq);
        end
        checks++;
        if (s[2].be !== 4'hF || s[2].we !== 1'b0 || s[2].addr !== 32'h20) begin
            failures++; $display("FAIL rd_req_fields got be=%h we=%b addr=%h exp f 0 00000020", s[2].be, s[2].we, s[2].addr);
        end
        checks++;
        if (s[8].rv !== 1'b1 || s[8].rdata !== 32'h12345678 || s[8].rresp !== 2'b00 || rc != 1) begin
            failures++; $display("FAIL rd_resp got rv=%b rdata=%h rresp=%b count=%0d exp 1 12345678 00 1",
                                 s[8].rv, s[8].rdata, s[8].rresp, rc);
        end
        gnt_dly = 0; rv_dly = 1;
    endtask

    task automatic test_error();
        tick();
        cfg_err = 1;
        axi.awaddr = 32'h80; axi.awvalid = 1;
        axi.wdata = 32'h5; axi.wstrb = 4'hF; axi.wvalid = 1;
        run(6, 0, 0);
        checks++;
        if (s[4].bv !== 1'b1 || s[4].bresp !== 2'b10) begin
            failures++; $display("FAIL err_bresp got bv=%b bresp=%b exp 1 10", s[4].bv, s[4].bresp);
        end
        tick();
        cfg_rdata = 32'hFFFF0000;
        axi.araddr = 32'h84; axi.arvalid = 1;
        run(6, 0, 0);
        checks++;
        if (s[4].rv !== 1'b1 || s[4].rresp !== 2'b10 || s[4].rdata !== 32'h0) begin
            failures++; $display("FAIL err_rresp got rv=%b rresp=%b rdata=%h exp 1 10 00000000", s[4].rv, s[4].rresp, s[4].rdata);
        end
        cfg_err = 0;
    endtask

    task automatic test_arbitration();
        int bad;
        tick(); rst = 1;
        tick(); rst = 0;
        cfg_rdata = 32'h0BADF00D;
        axi.bready = 0;
        axi.awaddr = 32'h100; axi.awvalid = 1;
        axi.wdata = 32'h11112222; axi.wstrb = 4'hF; axi.wvalid = 1;
        axi.araddr = 32'h200; axi.arvalid = 1;
        run(14, 0, 9);
        checks++;
        if (s[2].req !== 1'b1 || s[2].we !== 1'b1 || s[2].addr !== 32'h100) begin
            failures++; $display("FAIL arb1_first got req=%b we=%b addr=%h exp 1 1 00000100", s[2].req, s[2].we, s[2].addr);
        end
        bad = 0;
        for (int k = 4; k <= 8; k++)
            if (s[k].bv !== 1'b1 || s[k].bresp !== 2'b00 || s[k].req !== 1'b0) bad++;
        checks++;
        if (bad != 0 || s[5].arr !== 1'b0) begin
            failures++; $display("FAIL arb1_b_hold got %0d bad cycles arr=%b exp 0 0", bad, s[5].arr);
        end
        checks++;
        if (s[9].bv !== 1'b1 || s[10].bv !== 1'b0) begin
            failures++; $display("FAIL arb1_b_accept got bv9=%b bv10=%b exp 1 0", s[9].bv, s[10].bv);
        end
        checks++;
        if (s[11].req !== 1'b1 || s[11].we !== 1'b0 || s[11].addr !== 32'h200) begin
            failures++; $display("FAIL arb1_second got req=%b we=%b addr=%h exp 1 0 00000200", s[11].req, s[11].we, s[11].addr);
        end
        checks++;
        if (s[13].rv !== 1'b1 || s[13].rdata !== 32'h0BADF00D) begin
            failures++; $display("FAIL arb1_r got rv=%b rdata=%h exp 1 0badf00d", s[13].rv, s[13].rdata);
        end
        // lone write leaves the write as most recently served
        tick();
        axi.awaddr = 32'h300; axi.awvalid = 1;
        axi.wdata = 32'h33; axi.wstrb = 4'h1; axi.wvalid = 1;
        run(6, 0, 0);
        checks++;
        if (s[4].bv !== 1'b1) begin
            failures++; $display("FAIL arb_mid_b got bv=%b exp 1", s[4].bv);
        end
        tick();
        axi.awaddr = 32'h500; axi.awvalid = 1;
        axi.wdata = 32'h55; axi.wstrb = 4'hF; axi.wvalid = 1;
        axi.araddr = 32'h400; axi.arvalid = 1;
        run(12, 0, 0);
        checks++;
        if (s[2].req !== 1'b1 || s[2].we !== 1'b0 || s[2].addr !== 32'h400 || s[4].rv !== 1'b1) begin
            failures++; $display("FAIL arb2_first got req=%b we=%b addr=%h rv4=%b exp 1 0 00000400 1",
                                 s[2].req, s[2].we, s[2].addr, s[4].rv);
        end
        checks++;
        if (s[6].req !== 1'b1 || s[6].we !== 1'b1 || s[6].addr !== 32'h500 || s[8].bv !== 1'b1) begin
            failures++; $display("FAIL arb2_second got req=%b we=%b addr=%h bv8=%b exp 1 1 00000500 1",
                                 s[6].req, s[6].we, s[6].addr, s[8].bv);
        end
    endtask

    task automatic test_reset_midop();
        int act;
        tick();
        gnt_dly = 0; rv_dly = 4;
        axi.bready = 1;
        axi.awaddr = 32'h600; axi.awvalid = 1;
        axi.wdata = 32'h66; axi.wstrb = 4'hF; axi.wvalid = 1;
        tick();
        axi.awvalid = 0; axi.wvalid = 0;
        tick();
        axi.araddr = 32'h700; axi.arvalid = 1;
        @(negedge clk);
        checks++;
        if (dev_req_o !== 1'b1) begin
            failures++; $display("FAIL midrst_req got %b exp 1", dev_req_o);
        end
        tick();
        axi.arvalid = 0; rst = 1;
        @(negedge clk);
        checks++;
        if (dev_req_o !== 1'b0 || axi.arready !== 1'b0) begin
            failures++; $display("FAIL midrst_wait got req=%b arr=%b exp 0 0", dev_req_o, axi.arready);
        end
        tick();
        rst = 0;
        @(negedge clk);
        checks++;
        if (axi.bvalid !== 1'b0 || dev_req_o !== 1'b0 || {axi.awready, axi.wready, axi.arready} !== 3'b111) begin
            failures++; $display("FAIL midrst_after got bv=%b req=%b readies=%b exp 0 0 111",
                                 axi.bvalid, dev_req_o, {axi.awready, axi.wready, axi.arready});
        end
        run(10, 0, 0);
        act = 0;
        for (int k = 1; k <= 10; k++) if (s[k].bv || s[k].rv || s[k].req) act++;
        checks++;
        if (act != 0) begin
            failures++; $display("FAIL midrst_late_rvalid got %0d active cycles exp 0", act);
        end
        gnt_dly = 0; rv_dly = 1;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_read_stall();
        test_error();
        test_arbitration();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
